// File: rtl/multichannel_delay_line_pkg.sv
// Shared widths and FSM encoding for the multichannel delay line.
package multichannel_delay_line_pkg;

  localparam int DelayDataWidth = 16;
  localparam int DelayAddrWidth = 10;
  localparam int DelayChannels  = 2;
  localparam int DelayChWidth   = 1;

  // fb_shift code that disables the feedback path
  localparam logic [3:0] FbOff = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multichannel_delay_line_sync_ram_sp.sv
// Single-port RAM with registered, read-first output.
module sync_ram_sp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/multichannel_delay_line.sv
// Multichannel delay line: per-channel circular buffers in one single-port RAM.
// Define DELAYLINE_FEEDBACK_EN to add saturating feedback controlled by fb_shift.
module multichannel_delay_line
  import multichannel_delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = DelayDataWidth,
  parameter int ADDR_WIDTH = DelayAddrWidth,
  parameter int CHANNELS   = DelayChannels,
  parameter int CH_WIDTH   = DelayChWidth
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] delay,
`ifdef DELAYLINE_FEEDBACK_EN
  input  logic [3:0]                     fb_shift,
`endif
  output logic                           out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int RAM_AW = CH_WIDTH + ADDR_WIDTH;
  localparam int DW     = DATA_WIDTH;
  localparam int AW     = ADDR_WIDTH;

  state_e                   state_q, state_d;
  logic [CH_WIDTH-1:0]      ch_q, ch_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]              fill_q, fill_d;
  logic [CHANNELS*DW-1:0]   stage_q, stage_d;
  logic [CHANNELS*DW-1:0]   out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [CHANNELS*DW-1:0]   data_q;
  logic [CHANNELS*AW-1:0]   delay_q;

  logic                     xfer;
  logic [DW-1:0]            cur_in;
  logic [AW-1:0]            cur_dly;
  logic [AW-1:0]            rd_off;
  logic [DW-1:0]            ch_out;
  logic                     ram_we;
  logic [RAM_AW-1:0]        ram_addr;
  logic [DW-1:0]            ram_wdata;
  logic [DW-1:0]            ram_rdata;

  assign in_ready  = (state_q == IDLE);
  assign xfer      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    cur_in  = '0;
    cur_dly = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == CH_WIDTH'(k)) begin
        cur_in  = data_q[k*DW +: DW];
        cur_dly = delay_q[k*AW +: AW];
      end
    end
  end

  // Channel k lives at {k, offset}, i.e. k*DEPTH + offset
  assign rd_off   = wr_ptr_q - cur_dly;
  assign ram_addr = {ch_q, (state_q == WR) ? wr_ptr_q : rd_off};
  assign ram_we   = (state_q == WR) && !rst;

  always_comb begin
    ch_out = ram_rdata;
    if (cur_dly == '0)
      ch_out = cur_in;
    else if ({1'b0, cur_dly} > fill_q)
      ch_out = '0;
  end

`ifdef DELAYLINE_FEEDBACK_EN
  logic [3:0]           fb_q;
  logic signed [DW-1:0] fb_term;
  logic [DW:0]          fb_sum;

  always_comb begin
    fb_term = $signed(ch_out) >>> fb_q;
    if (fb_q == FbOff) fb_term = '0;
    fb_sum    = {cur_in[DW-1], cur_in} + {fb_term[DW-1], fb_term};
    ram_wdata = fb_sum[DW-1:0];
    if (fb_sum[DW] != fb_sum[DW-1])
      ram_wdata = fb_sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                             : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (xfer) fb_q <= fb_shift;
  end
`else
  assign ram_wdata = cur_in;
`endif

  sync_ram_sp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    stage_d     = stage_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ch_d    = '0;
          state_d = RD;
        end
      end
      RD: state_d = WR;
      WR: begin
        for (int k = 0; k < CHANNELS; k++)
          if (ch_q == CH_WIDTH'(k)) stage_d[k*DW +: DW] = ch_out;
        if (ch_q == CH_WIDTH'(CHANNELS-1)) begin
          state_d = DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = RD;
        end
      end
      DONE: begin
        out_data_d  = stage_q;
        out_valid_d = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        if (fill_q != (AW+1)'(DEPTH)) fill_d = fill_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      stage_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      stage_q     <= stage_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      data_q  <= in_data;
      delay_q <= delay;
    end
  end

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Randomised scoreboard bench for multichannel_delay_line (small RAM for wrap).
module tb_multichannel_delay_line;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int CH  = 2;
  localparam int CHW = 1;
  localparam int LAT = 2*CH + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [CH*DW-1:0] in_data;
  logic [CH*AW-1:0] delay;
  logic            out_valid;
  logic [CH*DW-1:0] out_data;
`ifdef DELAYLINE_FEEDBACK_EN
  logic [3:0]      fb_shift;
`endif

  multichannel_delay_line #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CHANNELS  (CH),
    .CH_WIDTH  (CHW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .delay    (delay),
`ifdef DELAYLINE_FEEDBACK_EN
    .fb_shift (fb_shift),
`endif
    .out_valid(out_valid),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [CH*DW-1:0] data;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   hist[CH][$];
  int   next_free = 0;
  int   sh = 15;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  // Reference: each channel is the list of values written since reset
  function automatic logic [CH*DW-1:0] model(input logic [CH*DW-1:0] din,
                                             input logic [CH*AW-1:0] dl,
                                             input int shift);
    logic [CH*DW-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      int x, d, n, y, w;
      x = $signed(din[k*DW +: DW]);
      d = int'(dl[k*AW +: AW]);
      n = hist[k].size();
      if (d == 0)     y = x;
      else if (d > n) y = 0;
      else            y = hist[k][n-d];
      w = x;
      if (shift != 15) begin
        w = x + (y >>> shift);
        if (w > 32767)  w = 32767;
        if (w < -32768) w = -32768;
      end
      hist[k].push_back(w);
      r[k*DW +: DW] = y[DW-1:0];
    end
    return r;
  endfunction

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    for (int k = 0; k < CH; k++) hist[k].delete();
    next_free = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
  endtask

  task automatic run(input int nfr, input bit ramp,
                     input logic [CH*AW-1:0] dly);
    int sent = 0;
    int budget = 0;
`ifdef DELAYLINE_FEEDBACK_EN
    sh = $urandom_range(0, 15);
    fb_shift = 4'(sh);
`endif
    while (sent < nfr && budget < nfr*40) begin
      @(negedge clk);
      budget++;
      check("in_ready", in_ready, cyc >= next_free);
      if (ramp) begin
        in_valid = 1'b1;
        for (int k = 0; k < CH; k++) in_data[k*DW +: DW] = DW'(sent + 1);
        delay = dly;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        delay    = CH*AW'($urandom);
      end
      if (in_valid && in_ready) begin
        sb.push_back('{model(in_data, delay, sh), cyc + 1 + LAT});
        next_free = cyc + 1 + LAT;
        sent++;
      end
    end
    if (sent < nfr) begin
      compared++;
      mismatched++;
      $display("FAIL run_budget: sent %0d of %0d frames", sent, nfr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_out_valid @cyc %0d: got pulse, required none", cyc);
      end else begin
        e = sb.pop_front();
        check("out_latency", 64'(cyc), 64'(e.due));
        check("out_data", out_data, e.data);
      end
    end
  end

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    delay    = '0;
    rst      = 1'b1;
`ifdef DELAYLINE_FEEDBACK_EN
    fb_shift = 4'd15;
`endif
    do_reset(3);

    // random traffic leaves stale data all over the RAM
    run(200, 1'b0, '0);

    // after reset the stale words must never leak out
    @(negedge clk);
    do_reset(2);
    run(12, 1'b1, {3'd0, 3'd5});
    run(10, 1'b1, {3'd0, 3'd3});
    run(20, 1'b1, {3'd7, 3'd7});
    run(6,  1'b1, {3'd1, 3'd1});

    // abort a frame during the first channel's write cycle
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = $urandom;
    delay    = {3'd0, 3'd0};
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    do_reset(2);
    repeat (8) @(negedge clk);

    run(150, 1'b0, '0);

    repeat (20) @(negedge clk);
    check("drain_pending", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
